// File: rtl/i2s_dac_tx_if.sv
// Mono sample stream into the I2S DAC transmitter.
interface i2s_dac_tx_if #(
  parameter int W = 16
) ();
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for the WM8731 DAC: FIFO-buffered mono samples, serialised MSB-first
// into both channels, with codec-mastered BCLK/DACLRCK oversampled in the clk domain.
module i2s_dac_tx #(
  parameter int W          = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  i2s_dac_tx_if.slave                   s_in,
  input  logic                          bclk,
  input  logic                          daclrck,
  output logic                          dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(W + 1);
  localparam logic [AW:0]   DEPTH_L = AW'(0) + (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] W_L     = CW'(W);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t        r_state;
  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_b_s1, r_b_s2, r_b_prev;
  logic          r_lr_s1, r_lr_s2, r_lr_prev;
  logic [W-1:0]  r_shreg, r_hold;
  logic [CW-1:0] r_bit_cnt;
  logic          r_dacdat, r_underflow, r_ch_pend;

  logic          w_bfall, w_lr_edge, w_lr_fall;
  logic          w_full, w_empty, w_push, w_pop;
  logic          w_ch_trig, w_ch_start, w_shift;
  logic [W-1:0]  w_frame_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b_s1    <= 1'b0;
      r_b_s2    <= 1'b0;
      r_b_prev  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_b_s1    <= bclk;
      r_b_s2    <= r_b_s1;
      r_b_prev  <= r_b_s2;
      r_lr_s1   <= daclrck;
      r_lr_s2   <= r_lr_s1;
      r_lr_prev <= r_lr_s2;
    end
  end

  always_comb begin
    w_bfall      = r_b_prev & ~r_b_s2;
    w_lr_edge    = r_lr_prev ^ r_lr_s2;
    w_lr_fall    = r_lr_prev & ~r_lr_s2;
    w_full       = (r_level == DEPTH_L);
    w_empty      = (r_level == '0);
    w_push       = s_in.sample_valid & ~w_full;
    w_pop        = w_lr_fall & ~w_empty;
    w_frame_word = w_empty ? '0 : r_mem[r_rd_ptr];
    // An LR edge that lands between BCLK falls is remembered until the next fall;
    // before RUN only the left-channel start is honoured.
    w_ch_trig    = (r_state == RUN) ? (w_lr_edge | r_ch_pend) : w_lr_fall;
    w_ch_start   = w_bfall & w_ch_trig;
    w_shift      = w_bfall & ~w_ch_trig & (r_state == RUN);
  end

  assign s_in.sample_ready = ~w_full;
  assign fifo_level        = r_level;
  assign dacdat            = r_dacdat;
  assign underflow         = r_underflow;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.sample_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC_WAIT;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_bit_cnt   <= W_L;
      r_dacdat    <= 1'b0;
      r_underflow <= 1'b0;
      r_ch_pend   <= 1'b0;
    end else begin
      r_underflow <= w_lr_fall & w_empty;
      r_ch_pend   <= ~w_bfall & w_ch_trig;
      if (w_lr_fall) begin
        r_state <= RUN;
        r_hold  <= w_frame_word;
      end
      if (w_ch_start) begin
        // The left channel must carry the word popped in this very cycle.
        r_shreg   <= w_lr_fall ? w_frame_word : r_hold;
        r_bit_cnt <= '0;
        r_dacdat  <= 1'b0;
      end else if (w_shift) begin
        if (r_bit_cnt < W_L) begin
          r_dacdat  <= r_shreg[W-1];
          r_shreg   <= {r_shreg[W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end else begin
          r_dacdat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: acts as the codec (BCLK/DACLRCK master, capture on BCLK rise).
module tb_i2s_dac_tx;

  logic       clk = 1'b0;
  logic       reset, bclk, daclrck;
  logic       dacdat, underflow;
  logic [2:0] fifo_level;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned uf_cycles = 0, uf_pulses = 0;
  logic        uf_prev = 1'b0;

  i2s_dac_tx_if #(.W(16)) u_if ();

  i2s_dac_tx #(.W(16), .FIFO_DEPTH(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .s_in       (u_if),
    .bclk       (bclk),
    .daclrck    (daclrck),
    .dacdat     (dacdat),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (underflow) uf_cycles++;
    if (underflow && !uf_prev) uf_pulses++;
    uf_prev = underflow;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One channel slot as captured: delay bit 0, 16-bit word MSB-first, zero padding.
  function automatic logic [31:0] slot(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  task automatic push(input logic [15:0] d, output logic acc);
    u_if.sample_valid = 1'b1;
    u_if.sample_data  = d;
    acc = u_if.sample_ready;
    @(negedge clk);
    u_if.sample_valid = 1'b0;
  endtask

  // One BCLK period: fall (LR updates), 3 clk low, rise with capture, 3 clk high.
  task automatic bclk_cycle(input logic lr, input logic do_push, input logic [15:0] pd,
                            output logic cap, output logic acc);
    acc     = 1'b0;
    bclk    = 1'b0;
    daclrck = lr;
    @(negedge clk);
    @(negedge clk);
    if (do_push) begin
      u_if.sample_valid = 1'b1;
      u_if.sample_data  = pd;
      acc = u_if.sample_ready;
    end
    @(negedge clk);
    u_if.sample_valid = 1'b0;
    bclk = 1'b1;
    cap  = dacdat;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_channel(input logic lr, input int nb, input logic do_push,
                             input logic [15:0] pd, output logic [31:0] cap, output logic acc);
    logic b, a;
    cap = '0;
    acc = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bclk_cycle(lr, do_push && (i == 0), pd, b, a);
      cap[31-i] = b;
      if (i == 0) acc = a;
    end
  endtask

  task automatic run_frame(input int nb, input logic do_push, input logic [15:0] pd,
                           output logic [31:0] l, output logic [31:0] r, output logic acc);
    logic dummy;
    run_channel(1'b0, nb, do_push, pd, l, acc);
    run_channel(1'b1, nb, 1'b0, 16'h0000, r, dummy);
  endtask

  logic [15:0] t3 [5] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hC001, 16'h5A5A};
  logic [15:0] t5 [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};

  initial begin
    logic [31:0] l, r;
    logic        acc, b, silent;
    int unsigned p0, c0;

    reset = 1'b1; bclk = 1'b1; daclrck = 1'b1;
    u_if.sample_valid = 1'b0; u_if.sample_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_dacdat", dacdat, 0);
    check_eq("rst_underflow", underflow, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ready", u_if.sample_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Single word
    push(16'hA5C3, acc);
    check_eq("t2_accept", acc, 1);
    check_eq("t2_level1", fifo_level, 1);
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t2_left", l, slot(16'hA5C3));
    check_eq("t2_right", r, slot(16'hA5C3));
    check_eq("t2_level0", fifo_level, 0);
    check_eq("t2_no_underflow", uf_pulses, 0);

    // FIFO full
    for (int k = 0; k < 5; k++) begin
      push(t3[k], acc);
      check_eq($sformatf("t3_ready%0d", k), acc, (k < 4) ? 1 : 0);
    end
    check_eq("t3_level4", fifo_level, 4);
    check_eq("t3_ready_full", u_if.sample_ready, 0);
    for (int k = 0; k < 4; k++) begin
      run_frame(32, 1'b0, 16'h0, l, r, acc);
      check_eq($sformatf("t3_left%0d", k), l, slot(t3[k]));
      check_eq($sformatf("t3_right%0d", k), r, slot(t3[k]));
    end

    // Push coinciding with the frame-start pop
    for (int k = 0; k < 4; k++) push(t5[k], acc);
    check_eq("t5_level4", fifo_level, 4);
    run_frame(32, 1'b1, 16'h7777, l, r, acc);
    check_eq("t5_refused", acc, 0);
    check_eq("t5_level3", fifo_level, 3);
    check_eq("t5_left0", l, slot(t5[0]));
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t5_left1", l, slot(t5[1]));
    check_eq("t5_level2a", fifo_level, 2);
    run_frame(32, 1'b1, 16'h4242, l, r, acc);
    check_eq("t5_accepted", acc, 1);
    check_eq("t5_level2b", fifo_level, 2);
    check_eq("t5_left2", l, slot(t5[2]));
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t5_left3", l, slot(t5[3]));
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t5_left_pushed", l, slot(16'h4242));
    check_eq("t5_level0", fifo_level, 0);

    // Underflow
    p0 = uf_pulses; c0 = uf_cycles;
    for (int k = 0; k < 2; k++) begin
      run_frame(32, 1'b0, 16'h0, l, r, acc);
      check_eq($sformatf("t4_left%0d", k), l, 0);
      check_eq($sformatf("t4_right%0d", k), r, 0);
    end
    check_eq("t4_pulses", uf_pulses - p0, 2);
    check_eq("t4_pulse_cycles", uf_cycles - c0, 2);

    // Sign / edge values
    push(16'h8000, acc);
    push(16'h7FFF, acc);
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t6_left8000", l, slot(16'h8000));
    check_eq("t6_right8000", r, slot(16'h8000));
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t6_left7fff", l, slot(16'h7FFF));
    check_eq("t6_right7fff", r, slot(16'h7FFF));

    // Short frame: 12 BCLKs per channel truncates the word
    push(16'hA5C3, acc);
    run_frame(12, 1'b0, 16'h0, l, r, acc);
    check_eq("short_left", l, slot(16'hA5C3) & 32'hFFF0_0000);
    check_eq("short_right", r, slot(16'hA5C3) & 32'hFFF0_0000);

    // Reset mid-shift
    push(16'hFFFF, acc);
    push(16'hFFFF, acc);
    for (int k = 0; k < 5; k++) bclk_cycle(1'b0, 1'b0, 16'h0, b, acc);
    check_eq("t1_shifting", dacdat, 1);
    check_eq("t1_level_pre", fifo_level, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t1_dacdat", dacdat, 0);
    check_eq("t1_level", fifo_level, 0);
    check_eq("t1_ready", u_if.sample_ready, 1);
    check_eq("t1_underflow", underflow, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(16'hFFFF, acc);
    silent = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bclk_cycle(1'b0, 1'b0, 16'h0, b, acc);
      silent = silent | b | dacdat;
    end
    for (int k = 0; k < 8; k++) begin
      bclk_cycle(1'b1, 1'b0, 16'h0, b, acc);
      silent = silent | b | dacdat;
    end
    check_eq("t1_silent", silent, 0);
    run_frame(32, 1'b0, 16'h0, l, r, acc);
    check_eq("t1_resume_left", l, slot(16'hFFFF));
    check_eq("t1_resume_right", r, slot(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
